// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
//   Shared definitions for the SRAM read/write control path and its consumers:
//   default word/FIFO geometry and the read-strobe decode used both by the
//   word collector and by the control generator's bench.
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 4;

    // A sense-amp strobe is a read only when it is not part of a write cycle.
    function automatic logic rd_decode(input logic sa_en, input logic write_bit);
        return sa_en & ~write_bit;
    endfunction

endpackage

// File: rtl/sa_word_fifo.sv
// -----------------------------------------------------------------------------
// sa_word_fifo
//   Synchronous FIFO with occupancy counter and a registered head output.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     push         request to write push_data
//     push_data    word to enqueue
//     pop          request to dequeue the head (ignored while empty)
//     head_data    registered head-of-queue word (0 while empty)
//     head_valid   registered non-empty flag
//     full, empty  occupancy flags
//     count        current occupancy, 0..DEPTH
//     push_refused push requested but not accepted (full, no pop this cycle)
// -----------------------------------------------------------------------------
module sa_word_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned W     = DEF_DATA_W,
    parameter int unsigned DEPTH = DEF_DEPTH     // power of two, >= 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head_data,
    output logic                       head_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       push_refused
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_next;
    logic [CNT_W-1:0] count_q, count_next;
    logic [W-1:0]     head_q, head_next;
    logic             valid_q;
    logic             push_en, pop_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle, since the freed slot is the one the write pointer addresses.
    assign pop_en       = pop & ~empty;
    assign push_en      = push & (~full | pop_en);
    assign push_refused = push & ~push_en;

    // NOTE: every signal assigned in always_comb gets a default first so that
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_next  = count_q;
        rd_ptr_next = rd_ptr_q;
        head_next   = '0;
        case ({push_en, pop_en})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
        if (pop_en) begin
            rd_ptr_next = rd_ptr_q + 1'b1;
        end
        // The new head is either an existing entry or, when the queue is (or
        // becomes) otherwise empty, the word being written this very cycle.
        if (count_next != '0) begin
            if (push_en && (wr_ptr_q == rd_ptr_next)) begin
                head_next = push_data;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    // NOTE: storage array is deliberately not reset; only pointers, count and
    // the head register are, so unread entries are never observable.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            rd_ptr_q <= rd_ptr_next;
            count_q  <= count_next;
            head_q   <= head_next;
            valid_q  <= (count_next != '0);
        end
    end

    assign head_data  = head_q;
    assign head_valid = valid_q;
    assign count      = count_q;

endmodule

// File: rtl/sa_word_collector.sv
// -----------------------------------------------------------------------------
// sa_word_collector
//   Assembles sense-amp read bits into DATA_W-bit words and queues them for the
//   host-side read path.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     sa_en        sense-amp enable strobe from the control generator
//     write_bit    write-cycle indicator (suppresses capture)
//     sa_out       sense-amp result, valid the cycle after a read strobe
//     flush        drop the partial word and clear overflow
//     word_data    head-of-queue word, bit i = i-th captured bit
//     word_valid   queue non-empty
//     word_ready   consumer accepts word_data this cycle
//     fill_level   queue occupancy
//     bit_count    bits held in the partial word
//     overflow     sticky: a completed word was dropped
// -----------------------------------------------------------------------------
module sa_word_collector
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,  // >= 2
    parameter int unsigned DEPTH  = DEF_DEPTH    // power of two, >= 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sa_en,
    input  logic                       write_bit,
    input  logic                       sa_out,
    input  logic                       flush,
    output logic [DATA_W-1:0]          word_data,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic [$clog2(DATA_W)-1:0]  bit_count,
    output logic                       overflow
);

    localparam int unsigned BC_W = $clog2(DATA_W);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

    logic              rd_q;
    logic [BC_W-1:0]   bit_count_q;
    logic [DATA_W-1:0] shift_q;
    logic              overflow_q;

    logic              capture;
    logic              word_done;
    logic [DATA_W-1:0] full_word;
    logic              push_refused;
    logic              fifo_full, fifo_empty;

    // The generator's strobes are registered here; sa_out is then valid in
    // the cycle where rd_q is high. flush kills an in-flight capture.
    assign capture   = rd_q & ~flush;
    assign word_done = capture && (bit_count_q == LAST_BIT);

    // The completing bit is merged combinationally so the word can be pushed
    // on the same edge that captures its last bit.
    always_comb begin
        full_word              = shift_q;
        full_word[DATA_W-1]    = sa_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q        <= 1'b0;
            bit_count_q <= '0;
            shift_q     <= '0;
            overflow_q  <= 1'b0;
        end else if (flush) begin
            rd_q        <= 1'b0;
            bit_count_q <= '0;
            shift_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            rd_q <= rd_decode(sa_en, write_bit);
            if (capture) begin
                if (word_done) begin
                    bit_count_q <= '0;
                    shift_q     <= '0;
                end else begin
                    bit_count_q          <= bit_count_q + 1'b1;
                    shift_q[bit_count_q] <= sa_out;
                end
            end
            if (push_refused) begin
                overflow_q <= 1'b1;
            end
        end
    end

    sa_word_fifo #(
        .W     (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (word_done),
        .push_data    (full_word),
        .pop          (word_ready),
        .head_data    (word_data),
        .head_valid   (word_valid),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .count        (fill_level),
        .push_refused (push_refused)
    );

    assign bit_count = bit_count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sa_word_collector.sv
// -----------------------------------------------------------------------------
// tb_sa_word_collector
//   Directed bench for sa_word_collector with DATA_W = 8, DEPTH = 4.
//   Inputs change 1 time unit after each rising edge; outputs are checked at
//   that same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_sa_word_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sa_en;
    logic       write_bit;
    logic       sa_out;
    logic       flush;
    logic [7:0] word_data;
    logic       word_valid;
    logic       word_ready;
    logic [2:0] fill_level;
    logic [2:0] bit_count;
    logic       overflow;

    int tests_run = 0;
    int tests_failed = 0;

    sa_word_collector #(
        .DATA_W (8),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sa_en      (sa_en),
        .write_bit  (write_bit),
        .sa_out     (sa_out),
        .flush      (flush),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .fill_level (fill_level),
        .bit_count  (bit_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's strobes, then advance past the next rising edge.
    task automatic step(input logic en, input logic wr, input logic so);
        sa_en     = en;
        write_bit = wr;
        sa_out    = so;
        @(posedge clk);
        #1;
    endtask

    // Eight read strobes back to back; each strobe's bit is presented on the
    // following cycle. Optionally pop on the cycle the word completes.
    task automatic send_word(input logic [7:0] w, input logic pop_last);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, (i == 0) ? 1'b0 : w[i-1]);
        end
        word_ready = pop_last;
        step(1'b0, 1'b0, w[7]);
        word_ready = 1'b0;
    endtask

    task automatic pop_one();
        word_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        word_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(word_valid), 32'd0);
        check({tag, "_fill"},  32'(fill_level), 32'd0);
        check({tag, "_bitcnt"}, 32'(bit_count), 32'd0);
        check({tag, "_ovf"},   32'(overflow),   32'd0);
        check({tag, "_data"},  32'(word_data),  32'd0);
    endtask

    // Mixed read/write sequence: reads carry bits 1,0,1,0,0,1,0,1 -> 8'hA5.
    logic mx_en [12] = '{1,1,1,0,1,1,1,1,1,1,1,1};
    logic mx_wr [12] = '{0,1,0,1,0,0,1,0,0,0,1,0};
    logic mx_b  [12] = '{1,1,0,1,1,0,1,0,1,0,1,1};

    initial begin
        rst_n      = 1'b0;
        sa_en      = 1'b0;
        write_bit  = 1'b0;
        sa_out     = 1'b0;
        flush      = 1'b0;
        word_ready = 1'b0;
        #1;
        check_reset_state("reset");
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        check("post_release_bitcnt", 32'(bit_count), 32'd0);

        // ---- single word: 1,0,1,1,0,0,1,0 -> 8'h4D
        begin
            logic [7:0] w;
            w = 8'h4D;
            for (int i = 0; i < 8; i++) begin
                step(1'b1, 1'b0, (i == 0) ? 1'b0 : w[i-1]);
            end
            check("single_pre_valid", 32'(word_valid), 32'd0);
            check("single_pre_bitcnt", 32'(bit_count), 32'd7);
            step(1'b0, 1'b0, w[7]);
            check("single_valid", 32'(word_valid), 32'd1);
            check("single_data", 32'(word_data), 32'h4D);
            check("single_fill", 32'(fill_level), 32'd1);
            check("single_bitcnt", 32'(bit_count), 32'd0);
            step(1'b0, 1'b0, 1'b0);
            check("single_hold_data", 32'(word_data), 32'h4D);
            pop_one();
            check("single_drained_valid", 32'(word_valid), 32'd0);
            check("single_drained_fill", 32'(fill_level), 32'd0);
        end

        // ---- mixed read/write strobes
        for (int j = 0; j <= 12; j++) begin
            step((j < 12) ? mx_en[j] : 1'b0,
                 (j < 12) ? mx_wr[j] : 1'b0,
                 (j > 0)  ? mx_b[j-1] : 1'b0);
            if (j == 6) check("mixed_mid_bitcnt", 32'(bit_count), 32'd4);
        end
        check("mixed_valid", 32'(word_valid), 32'd1);
        check("mixed_data", 32'(word_data), 32'hA5);
        check("mixed_bitcnt", 32'(bit_count), 32'd0);
        pop_one();

        // ---- overflow: five words with no consumer
        for (int k = 1; k <= 4; k++) send_word(8'(k), 1'b0);
        check("ovf_fill4", 32'(fill_level), 32'd4);
        check("ovf_not_yet", 32'(overflow), 32'd0);
        send_word(8'h05, 1'b0);
        check("ovf_fill_after5", 32'(fill_level), 32'd4);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_head", 32'(word_data), 32'h01);

        // ---- flush after 3 captured bits, with a 4th capture pending
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check("flush_pre_bitcnt", 32'(bit_count), 32'd3);
        flush = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        flush = 1'b0;
        check("flush_bitcnt", 32'(bit_count), 32'd0);
        check("flush_ovf_clr", 32'(overflow), 32'd0);
        check("flush_fill", 32'(fill_level), 32'd4);
        check("flush_head", 32'(word_data), 32'h01);
        step(1'b0, 1'b0, 1'b1);
        check("flush_rdq_clr", 32'(bit_count), 32'd0);

        // ---- drain in order
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain_%0d", k), 32'(word_data), 32'(k));
            pop_one();
        end
        check("drain_fill", 32'(fill_level), 32'd0);
        check("drain_valid", 32'(word_valid), 32'd0);

        send_word(8'hC3, 1'b0);
        check("clean_word", 32'(word_data), 32'hC3);
        check("clean_fill", 32'(fill_level), 32'd1);
        pop_one();

        // ---- full FIFO, fifth word completes together with a pop
        for (int k = 0; k < 4; k++) send_word(8'(8'h11 + k), 1'b0);
        send_word(8'h15, 1'b1);
        check("simul_fill", 32'(fill_level), 32'd4);
        check("simul_ovf", 32'(overflow), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("simul_drain_%0d", k), 32'(word_data), 32'(8'h12 + k));
            pop_one();
        end
        check("simul_empty", 32'(fill_level), 32'd0);

        // ---- asynchronous reset mid-word with two words queued
        send_word(8'h21, 1'b0);
        send_word(8'h22, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("midrst_pre_bitcnt", 32'(bit_count), 32'd5);
        check("midrst_pre_fill", 32'(fill_level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        send_word(8'h96, 1'b0);
        check("postrst_data", 32'(word_data), 32'h96);
        check("postrst_fill", 32'(fill_level), 32'd1);
        check("postrst_bitcnt", 32'(bit_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
